// File: rtl/bcd_mod_counter_if.sv
// Control and digit bus of one BCD modulo-N counter stage.
// The controller drives the strobes; the counter returns digits and cascade pulses.
interface bcd_mod_counter_if;
    logic       tick;
    logic       dir;
    logic       set_mode;
    logic       sel_digit;
    logic       set_inc;
    logic       set_dec;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] v0;
    logic [3:0] v1;
    logic       co;
    logic       bo;
    logic       flag;
    logic       load_err;

    modport master (
        output tick, dir, set_mode, sel_digit, set_inc, set_dec, load, load_val,
        input  v0, v1, co, bo, flag, load_err
    );

    modport slave (
        input  tick, dir, set_mode, sel_digit, set_inc, set_dec, load, load_val,
        output v0, v1, co, bo, flag, load_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MODULUS up/down counter with digit-wise set mode,
// validated parallel load and registered carry/borrow pulses for cascading.
module bcd_mod_counter #(
    parameter int MODULUS = 60,
    parameter int INIT    = 0
) (
    input  logic              clk,
    input  logic              sclr,
    bcd_mod_counter_if.slave  bus
);

    localparam logic [3:0] TT_C    = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] TO_C    = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] INIT_T  = 4'(INIT / 10);
    localparam logic [3:0] INIT_O  = 4'(INIT % 10);
    localparam logic [7:0] MOD_C   = 8'(MODULUS);

    // Highest legal ones digit for a given tens digit.
    function automatic logic [3:0] max_ones(input logic [3:0] tens);
        return (tens == TT_C) ? TO_C : 4'd9;
    endfunction

    function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] top);
        return (d == top) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] d, input logic [3:0] top);
        return (d == 4'd0) ? top : d - 4'd1;
    endfunction

    logic [3:0] r_v1;
    logic [3:0] r_v0;
    logic       r_co;
    logic       r_bo;
    logic       r_load_err;

    logic [3:0] w_v1_nxt;
    logic [3:0] w_v0_nxt;
    logic       w_co_nxt;
    logic       w_bo_nxt;
    logic       w_load_err_nxt;
    logic [3:0] w_tens_new;
    logic [7:0] w_load_bin;
    logic       w_load_ok;
    logic       w_flag;

    // Binary value of the load word, valid only when both nibbles are decimal.
    always_comb begin
        w_load_bin = 8'({4'd0, bus.load_val[7:4]} * 8'd10) + {4'd0, bus.load_val[3:0]};
        w_load_ok  = (bus.load_val[7:4] <= 4'd9) && (bus.load_val[3:0] <= 4'd9)
                     && (w_load_bin < MOD_C);
    end

    // Next digits and pulses; load beats set mode, set mode beats the run tick.
    always_comb begin
        w_v1_nxt       = r_v1;
        w_v0_nxt       = r_v0;
        w_co_nxt       = 1'b0;
        w_bo_nxt       = 1'b0;
        w_load_err_nxt = 1'b0;
        w_tens_new     = r_v1;
        if (bus.load) begin
            if (w_load_ok) begin
                w_v1_nxt = bus.load_val[7:4];
                w_v0_nxt = bus.load_val[3:0];
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (bus.set_mode) begin
            if (bus.set_inc != bus.set_dec) begin
                if (!bus.sel_digit) begin
                    w_v0_nxt = bus.set_inc ? wrap_inc(r_v0, max_ones(r_v1))
                                           : wrap_dec(r_v0, max_ones(r_v1));
                end else begin
                    // Clamp ones so a tens change can never leave value >= MODULUS.
                    w_tens_new = bus.set_inc ? wrap_inc(r_v1, TT_C) : wrap_dec(r_v1, TT_C);
                    w_v1_nxt   = w_tens_new;
                    w_v0_nxt   = (r_v0 > max_ones(w_tens_new)) ? max_ones(w_tens_new) : r_v0;
                end
            end else begin
                w_v0_nxt = r_v0;
            end
        end else if (bus.tick) begin
            if (!bus.dir) begin
                if (r_v0 == max_ones(r_v1)) begin
                    w_v0_nxt = 4'd0;
                    if (r_v1 == TT_C) begin
                        w_v1_nxt = 4'd0;
                        w_co_nxt = 1'b1;
                    end else begin
                        w_v1_nxt = r_v1 + 4'd1;
                    end
                end else begin
                    w_v0_nxt = r_v0 + 4'd1;
                end
            end else begin
                if (r_v0 == 4'd0) begin
                    if (r_v1 == 4'd0) begin
                        w_v1_nxt = TT_C;
                        w_v0_nxt = TO_C;
                        w_bo_nxt = 1'b1;
                    end else begin
                        w_v1_nxt = r_v1 - 4'd1;
                        w_v0_nxt = 4'd9;
                    end
                end else begin
                    w_v0_nxt = r_v0 - 4'd1;
                end
            end
        end else begin
            w_v0_nxt = r_v0;
        end
    end

    // State and pulse registers with asynchronous clear to INIT.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            r_v1       <= INIT_T;
            r_v0       <= INIT_O;
            r_co       <= 1'b0;
            r_bo       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_v1       <= w_v1_nxt;
            r_v0       <= w_v0_nxt;
            r_co       <= w_co_nxt;
            r_bo       <= w_bo_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Look-ahead terminal count: the next run tick in the current direction wraps.
    always_comb begin
        if (bus.set_mode) begin
            w_flag = 1'b0;
        end else if (!bus.dir) begin
            w_flag = (r_v1 == TT_C) && (r_v0 == TO_C);
        end else begin
            w_flag = (r_v1 == 4'd0) && (r_v0 == 4'd0);
        end
    end

    assign bus.v0       = r_v0;
    assign bus.v1       = r_v1;
    assign bus.co       = r_co;
    assign bus.bo       = r_bo;
    assign bus.load_err = r_load_err;
    assign bus.flag     = w_flag;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: a minutes (60) and an hours (24) stage against a
// value-level model, with directed scenarios followed by randomized traffic.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    logic sclr;
    logic casc;
    logic tick24_drv;
    logic chk_en;

    always #5 clk = ~clk;

    bcd_mod_counter_if b60();
    bcd_mod_counter_if b24();

    assign b24.tick = casc ? b60.co : tick24_drv;

    bcd_mod_counter #(.MODULUS(60), .INIT(0)) u60 (.clk(clk), .sclr(sclr), .bus(b60.slave));
    bcd_mod_counter #(.MODULUS(24), .INIT(0)) u24 (.clk(clk), .sclr(sclr), .bus(b24.slave));

    typedef struct packed {
        logic [7:0] val;
        logic       co;
        logic       bo;
        logic       le;
    } mst_t;

    mst_t m60;
    mst_t m24;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int maxo(input int m, input int t);
        return (t == (m - 1) / 10) ? (m - 1) % 10 : 9;
    endfunction

    // Value-level reference: binary arithmetic modulo m, digits only where set mode needs them.
    function automatic mst_t mnext(input int m, input mst_t s, input logic tick, input logic dir,
                                   input logic setm, input logic sel, input logic inc,
                                   input logic dec, input logic ld, input logic [7:0] lv);
        mst_t r;
        int v, t, o, tt, lt, lo;
        v  = int'(s.val);
        t  = v / 10;
        o  = v % 10;
        tt = (m - 1) / 10;
        lt = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        r  = s;
        r.co = 1'b0;
        r.bo = 1'b0;
        r.le = 1'b0;
        if (ld) begin
            if (lt <= 9 && lo <= 9 && lt * 10 + lo < m) r.val = 8'(lt * 10 + lo);
            else r.le = 1'b1;
        end else if (setm) begin
            if (inc != dec) begin
                if (!sel) begin
                    if (inc) o = (o == maxo(m, t)) ? 0 : o + 1;
                    else     o = (o == 0) ? maxo(m, t) : o - 1;
                end else begin
                    if (inc) t = (t == tt) ? 0 : t + 1;
                    else     t = (t == 0) ? tt : t - 1;
                    if (o > maxo(m, t)) o = maxo(m, t);
                end
                r.val = 8'(t * 10 + o);
            end
        end else if (tick) begin
            if (!dir) begin
                r.co  = (v == m - 1);
                r.val = 8'((v + 1) % m);
            end else begin
                r.bo  = (v == 0);
                r.val = 8'((v + m - 1) % m);
            end
        end
        return r;
    endfunction

    function automatic logic mflag(input int m, input logic [7:0] val, input logic setm,
                                   input logic dir);
        return !setm && ((!dir && int'(val) == m - 1) || (dir && val == 8'd0));
    endfunction

    always @(posedge clk or posedge sclr) begin
        if (sclr) begin
            m60 <= '0;
            m24 <= '0;
        end else begin
            m60 <= mnext(60, m60, b60.tick, b60.dir, b60.set_mode, b60.sel_digit,
                         b60.set_inc, b60.set_dec, b60.load, b60.load_val);
            m24 <= mnext(24, m24, casc ? m60.co : tick24_drv, b24.dir, b24.set_mode,
                         b24.sel_digit, b24.set_inc, b24.set_dec, b24.load, b24.load_val);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output of both stages against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("u60_v1",   8'(b60.v1), m60.val / 8'd10);
            chk("u60_v0",   8'(b60.v0), m60.val % 8'd10);
            chk("u60_co",   8'(b60.co), 8'(m60.co));
            chk("u60_bo",   8'(b60.bo), 8'(m60.bo));
            chk("u60_lerr", 8'(b60.load_err), 8'(m60.le));
            chk("u60_flag", 8'(b60.flag), 8'(mflag(60, m60.val, b60.set_mode, b60.dir)));
            chk("u24_v1",   8'(b24.v1), m24.val / 8'd10);
            chk("u24_v0",   8'(b24.v0), m24.val % 8'd10);
            chk("u24_co",   8'(b24.co), 8'(m24.co));
            chk("u24_bo",   8'(b24.bo), 8'(m24.bo));
            chk("u24_lerr", 8'(b24.load_err), 8'(m24.le));
            chk("u24_flag", 8'(b24.flag), 8'(mflag(24, m24.val, b24.set_mode, b24.dir)));
        end
    end

    task automatic go();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        casc = 1'b0;  tick24_drv = 1'b0;
        b60.tick = 1'b0; b60.dir = 1'b0; b60.set_mode = 1'b0; b60.sel_digit = 1'b0;
        b60.set_inc = 1'b0; b60.set_dec = 1'b0; b60.load = 1'b0; b60.load_val = 8'h00;
        b24.dir = 1'b0; b24.set_mode = 1'b0; b24.sel_digit = 1'b0;
        b24.set_inc = 1'b0; b24.set_dec = 1'b0; b24.load = 1'b0; b24.load_val = 8'h00;
    endtask

    initial begin
        int n_co, n_bo;
        logic [7:0] exp3 [4];
        exp3 = '{8'h02, 8'h01, 8'h00, 8'h09};
        sclr = 1'b1;
        chk_en = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #1;
        sclr = 1'b0;
        chk_en = 1'b1;
        chk("rst_u60", {b60.v1, b60.v0}, 8'h00);
        chk("rst_u24", {b24.v1, b24.v0}, 8'h00);
        chk("rst_pulses", {5'd0, b60.co, b60.bo, b60.load_err}, 8'h00);

        // Sixty up-ticks on the minutes stage: one carry on 59 -> 00.
        b60.tick = 1'b1;
        n_co = 0; n_bo = 0;
        for (int i = 0; i < 60; i++) begin
            go();
            n_co += int'(b60.co);
            n_bo += int'(b60.bo);
            if (i == 58) begin
                chk("t1_at59", {b60.v1, b60.v0}, 8'h59);
                chk("t1_flag59", 8'(b60.flag), 8'h01);
            end
        end
        chk("t1_wrap", {b60.v1, b60.v0}, 8'h00);
        chk("t1_co_wrap", 8'(b60.co), 8'h01);
        chk("t1_co_count", 8'(n_co), 8'h01);
        chk("t1_bo_count", 8'(n_bo), 8'h00);
        b60.tick = 1'b0;

        // Hours stage counting down through zero.
        b24.dir = 1'b1; tick24_drv = 1'b1;
        go();
        chk("t2_wrap23", {b24.v1, b24.v0}, 8'h23);
        chk("t2_bo", 8'(b24.bo), 8'h01);
        n_bo = 0;
        repeat (23) begin
            go();
            n_bo += int'(b24.bo);
        end
        chk("t2_at00", {b24.v1, b24.v0}, 8'h00);
        chk("t2_no_bo", 8'(n_bo), 8'h00);
        tick24_drv = 1'b0; b24.dir = 1'b0;

        // Digit-wise set on the hours stage with tens clamping.
        b24.load = 1'b1; b24.load_val = 8'h19;
        go();
        b24.load = 1'b0;
        chk("t3_load19", {b24.v1, b24.v0}, 8'h19);
        b24.set_mode = 1'b1; b24.sel_digit = 1'b1; b24.set_inc = 1'b1;
        go();
        chk("t3_clamp23", {b24.v1, b24.v0}, 8'h23);
        go();
        chk("t3_tens_wrap", {b24.v1, b24.v0}, 8'h03);
        b24.sel_digit = 1'b0; b24.set_inc = 1'b0; b24.set_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go();
            chk("t3_ones_dec", {b24.v1, b24.v0}, exp3[i]);
            chk("t3_no_cobo", {6'd0, b24.co, b24.bo}, 8'h00);
        end
        b24.set_mode = 1'b0; b24.set_dec = 1'b0;

        // Load validation on the minutes stage.
        b60.load = 1'b1; b60.load_val = 8'h45;
        go();
        chk("t4_load45", {b60.v1, b60.v0}, 8'h45);
        chk("t4_ok", 8'(b60.load_err), 8'h00);
        b60.load_val = 8'h61;
        go();
        chk("t4_rej61", {b60.v1, b60.v0}, 8'h45);
        chk("t4_err61", 8'(b60.load_err), 8'h01);
        b60.load_val = 8'h3A;
        go();
        chk("t4_err3a", 8'(b60.load_err), 8'h01);
        b60.load_val = 8'h12; b60.set_mode = 1'b1; b60.set_inc = 1'b1;
        go();
        chk("t4_load_wins", {b60.v1, b60.v0}, 8'h12);
        b60.load = 1'b0; b60.set_mode = 1'b0; b60.set_inc = 1'b0;

        // Asynchronous clear between edges while counting.
        b60.load = 1'b1; b60.load_val = 8'h36;
        go();
        b60.load = 1'b0; b60.tick = 1'b1;
        go();
        chk("t5_at37", {b60.v1, b60.v0}, 8'h37);
        #2 sclr = 1'b1;
        #1;
        chk("t5_async", {b60.v1, b60.v0}, 8'h00);
        chk("t5_pulses", {5'd0, b60.co, b60.bo, b60.load_err}, 8'h00);
        go();
        chk("t5_hold", {b60.v1, b60.v0}, 8'h00);
        sclr = 1'b0;
        go();
        chk("t5_resume", {b60.v1, b60.v0}, 8'h01);
        b60.tick = 1'b0;

        // Cascade 23:59 -> 00:00.
        casc = 1'b1;
        b60.load = 1'b1; b60.load_val = 8'h59;
        b24.load = 1'b1; b24.load_val = 8'h23;
        go();
        b60.load = 1'b0; b24.load = 1'b0; b60.tick = 1'b1;
        go();
        chk("t6_min00", {b60.v1, b60.v0}, 8'h00);
        chk("t6_min_co", 8'(b60.co), 8'h01);
        chk("t6_hr23", {b24.v1, b24.v0}, 8'h23);
        b60.tick = 1'b0;
        go();
        chk("t6_hr00", {b24.v1, b24.v0}, 8'h00);
        chk("t6_hr_co", 8'(b24.co), 8'h01);
        casc = 1'b0;

        // Randomized traffic on both stages.
        for (int i = 0; i < 3000; i++) begin
            b60.tick = ($urandom % 4) != 0;   b60.dir = 1'($urandom);
            b60.set_mode = ($urandom % 6) == 0; b60.sel_digit = 1'($urandom);
            b60.set_inc = 1'($urandom);       b60.set_dec = 1'($urandom);
            b60.load = ($urandom % 16) == 0;
            b60.load_val = 1'($urandom) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            tick24_drv = ($urandom % 4) != 0; b24.dir = 1'($urandom);
            b24.set_mode = ($urandom % 6) == 0; b24.sel_digit = 1'($urandom);
            b24.set_inc = 1'($urandom);       b24.set_dec = 1'($urandom);
            b24.load = ($urandom % 16) == 0;
            b24.load_val = 1'($urandom) ? 8'($urandom) : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            if (($urandom % 400) == 0) begin
                sclr = 1'b1;
                #2 sclr = 1'b0;
            end
            go();
        end

        idle();
        go();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
